// File: rtl/io_stage.sv
// Memory-access stage: holds one instruction from execute, waits for load data,
// aligns and extends it, and presents the result to write-back and the decode bypass.
package cpu_core_params;
  localparam int ProgramCount = 32;
  localparam int CpuData      = 32;

  typedef struct packed {
    logic                    valid;
    logic [ProgramCount-1:0] program_count;
    logic                    memory_load;
    logic [2:0]              load_kind;
    logic                    register_file_write_enabled;
    logic [4:0]              register_file_address;
    logic [CpuData-1:0]      alu_result;
    logic [CpuData-1:0]      rt_value;
  } EXToIOData;

  typedef struct packed {
    logic [ProgramCount-1:0] program_count;
    logic                    memory_load;
    logic [2:0]              load_kind;
    logic                    register_file_write_enabled;
    logic [4:0]              register_file_address;
    logic [CpuData-1:0]      alu_result;
    logic [CpuData-1:0]      rt_value;
  } IOPayload;

  typedef struct packed {
    logic                    valid;
    logic [ProgramCount-1:0] program_count;
    logic                    register_file_write_enabled;
    logic [4:0]              register_file_address;
    logic [CpuData-1:0]      final_result;
  } IOToWBData;

  typedef struct packed {
    logic               valid;
    logic               data_ready;
    logic [4:0]         register_file_address;
    logic [CpuData-1:0] data;
  } IOToIDBypass;
endpackage

module io_stage
  import cpu_core_params::*;
(
  input  logic                clock,
  input  logic                reset,
  output logic                io_allow_in,
  input  EXToIOData           ex_to_io_bus,
  input  logic                wb_allow_in,
  output IOToWBData           io_to_wb_bus,
  input  logic                data_sram_data_ok,
  input  logic [CpuData-1:0]  data_sram_rdata,
  output IOToIDBypass         io_to_id_bypass
);

  logic               io_valid_q, io_valid_d;
  IOPayload           payload_q, payload_d;
  logic               data_buffered_q, data_buffered_d;
  logic [CpuData-1:0] rdata_buffer_q, rdata_buffer_d;

  logic               io_ready_go;
  logic               io_leave;
  logic [CpuData-1:0] load_word;
  logic [CpuData-1:0] final_result;
  logic [1:0]         addr_lo;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;
  logic [CpuData-1:0] rt;

  always_comb begin
    io_ready_go = !payload_q.memory_load || data_sram_data_ok || data_buffered_q;
    io_allow_in = !io_valid_q || (io_ready_go && wb_allow_in);
    io_leave    = io_valid_q && io_ready_go && wb_allow_in;
    load_word   = data_buffered_q ? rdata_buffer_q : data_sram_rdata;
  end

  always_comb begin
    io_valid_d      = io_valid_q;
    payload_d       = payload_q;
    data_buffered_d = data_buffered_q;
    rdata_buffer_d  = rdata_buffer_q;

    if (io_allow_in) io_valid_d = ex_to_io_bus.valid;

    if (ex_to_io_bus.valid && io_allow_in) begin
      payload_d.program_count               = ex_to_io_bus.program_count;
      payload_d.memory_load                 = ex_to_io_bus.memory_load;
      payload_d.load_kind                   = ex_to_io_bus.load_kind;
      payload_d.register_file_write_enabled = ex_to_io_bus.register_file_write_enabled;
      payload_d.register_file_address       = ex_to_io_bus.register_file_address;
      payload_d.alu_result                  = ex_to_io_bus.alu_result;
      payload_d.rt_value                    = ex_to_io_bus.rt_value;
    end

    // Capture the response only when WB stalls, since data_ok is a one-cycle pulse.
    if (io_leave) begin
      data_buffered_d = 1'b0;
    end else if (io_valid_q && payload_q.memory_load && data_sram_data_ok &&
                 !data_buffered_q && !wb_allow_in) begin
      data_buffered_d = 1'b1;
      rdata_buffer_d  = data_sram_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_valid_q      <= 1'b0;
      payload_q       <= '0;
      data_buffered_q <= 1'b0;
      rdata_buffer_q  <= '0;
    end else begin
      io_valid_q      <= io_valid_d;
      payload_q       <= payload_d;
      data_buffered_q <= data_buffered_d;
      rdata_buffer_q  <= rdata_buffer_d;
    end
  end

  always_comb begin
    addr_lo = payload_q.alu_result[1:0];
    rt      = payload_q.rt_value;

    case (addr_lo)
      2'd0:    byte_sel = load_word[7:0];
      2'd1:    byte_sel = load_word[15:8];
      2'd2:    byte_sel = load_word[23:16];
      default: byte_sel = load_word[31:24];
    endcase
    // Halfword alignment faults are trapped upstream, so only bit 1 matters.
    half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    final_result = payload_q.alu_result;
    if (payload_q.memory_load) begin
      case (payload_q.load_kind)
        3'd1: final_result = {{24{byte_sel[7]}}, byte_sel};
        3'd2: final_result = {24'd0, byte_sel};
        3'd3: final_result = {{16{half_sel[15]}}, half_sel};
        3'd4: final_result = {16'd0, half_sel};
        3'd5: begin
          case (addr_lo)
            2'd0:    final_result = {load_word[7:0],  rt[23:0]};
            2'd1:    final_result = {load_word[15:0], rt[15:0]};
            2'd2:    final_result = {load_word[23:0], rt[7:0]};
            default: final_result = load_word;
          endcase
        end
        3'd6: begin
          case (addr_lo)
            2'd0:    final_result = load_word;
            2'd1:    final_result = {rt[31:24], load_word[31:8]};
            2'd2:    final_result = {rt[31:16], load_word[31:16]};
            default: final_result = {rt[31:8],  load_word[31:24]};
          endcase
        end
        default: final_result = load_word;
      endcase
    end
  end

  always_comb begin
    io_to_wb_bus                             = '0;
    io_to_wb_bus.valid                       = io_valid_q && io_ready_go;
    io_to_wb_bus.program_count               = payload_q.program_count;
    io_to_wb_bus.register_file_write_enabled = payload_q.register_file_write_enabled;
    io_to_wb_bus.register_file_address       = payload_q.register_file_address;
    io_to_wb_bus.final_result                = final_result;

    io_to_id_bypass                       = '0;
    io_to_id_bypass.valid                 = io_valid_q && payload_q.register_file_write_enabled;
    io_to_id_bypass.data_ready            = io_ready_go;
    io_to_id_bypass.register_file_address = payload_q.register_file_address;
    io_to_id_bypass.data                  = final_result;
  end

endmodule

// File: tb/tb_io_stage.sv
// Directed bench for io_stage: reset, ALU pass-through, load alignment, WB stall
// buffering, streaming and asynchronous reset during an outstanding load.
module tb_io_stage;
  import cpu_core_params::*;

  logic        clock;
  logic        reset;
  logic        io_allow_in;
  EXToIOData   ex_to_io_bus;
  logic        wb_allow_in;
  IOToWBData   io_to_wb_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  IOToIDBypass io_to_id_bypass;

  int total = 0;
  int bad   = 0;

  io_stage dut (
    .clock            (clock),
    .reset            (reset),
    .io_allow_in      (io_allow_in),
    .ex_to_io_bus     (ex_to_io_bus),
    .wb_allow_in      (wb_allow_in),
    .io_to_wb_bus     (io_to_wb_bus),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .io_to_id_bypass  (io_to_id_bypass)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic ld,
                        input logic [2:0] kind, input logic we, input logic [4:0] addr,
                        input logic [31:0] alu, input logic [31:0] rt);
    ex_to_io_bus = '0;
    ex_to_io_bus.valid = v;
    ex_to_io_bus.program_count = pc;
    ex_to_io_bus.memory_load = ld;
    ex_to_io_bus.load_kind = kind;
    ex_to_io_bus.register_file_write_enabled = we;
    ex_to_io_bus.register_file_address = addr;
    ex_to_io_bus.alu_result = alu;
    ex_to_io_bus.rt_value = rt;
  endtask

  task automatic test_reset();
    set_ex(1, 32'hBFC0_0000, 0, 0, 1, 5'd3, 32'h55, 32'h0);
    #1;
    total++; if (io_allow_in !== 1'b1) begin bad++; $display("FAIL reset_allow_in: got %b want 1", io_allow_in); end
    total++; if (io_to_wb_bus !== '0) begin bad++; $display("FAIL reset_wb_bus: got %h want 0", io_to_wb_bus); end
    total++; if (io_to_id_bypass.valid !== 1'b0) begin bad++; $display("FAIL reset_bypass_valid: got %b want 0", io_to_id_bypass.valid); end
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    step();
    total++; if (io_to_wb_bus.valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid: got %b want 0", io_to_wb_bus.valid); end
  endtask

  task automatic test_alu();
    wb_allow_in = 1'b1;
    set_ex(1, 32'h0040_0010, 0, 0, 1, 5'd5, 32'h0000_1234, 32'hFFFF_FFFF);
    step();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (io_to_wb_bus.valid !== 1'b1) begin bad++; $display("FAIL alu_valid: got %b want 1", io_to_wb_bus.valid); end
    total++; if (io_to_wb_bus.final_result !== 32'h0000_1234) begin bad++; $display("FAIL alu_result: got %h want 00001234", io_to_wb_bus.final_result); end
    total++; if (io_to_wb_bus.register_file_write_enabled !== 1'b1 || io_to_wb_bus.register_file_address !== 5'd5)
      begin bad++; $display("FAIL alu_dest: got we=%b addr=%0d want we=1 addr=5", io_to_wb_bus.register_file_write_enabled, io_to_wb_bus.register_file_address); end
    total++; if (io_to_wb_bus.program_count !== 32'h0040_0010) begin bad++; $display("FAIL alu_pc: got %h want 00400010", io_to_wb_bus.program_count); end
    total++; if (io_to_id_bypass !== {1'b1, 1'b1, 5'd5, 32'h0000_1234}) begin bad++; $display("FAIL alu_bypass: got %h want valid/ready/5/00001234", io_to_id_bypass); end
    step();
    total++; if (io_to_wb_bus.valid !== 1'b0) begin bad++; $display("FAIL alu_drain: got %b want 0", io_to_wb_bus.valid); end
  endtask

  task automatic test_load_align();
    logic [2:0]  kinds [11] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd3, 3'd4, 3'd0, 3'd7, 3'd1, 3'd5, 3'd6};
    logic [1:0]  offs  [11] = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0, 2'd3};
    logic [31:0] rts   [11] = '{32'h0, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h0,
                                32'h0, 32'hAABBCCDD, 32'hAABBCCDD};
    logic [31:0] rds   [11] = '{32'h80FF_0000, 32'h80FF_0000, 32'h1122_3344, 32'h1122_3344,
                                32'h8001_1234, 32'h8001_1234, 32'h1234_5678, 32'h1234_5678,
                                32'h0000_007F, 32'h1122_3344, 32'h1122_3344};
    logic [31:0] exps  [11] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'h3344_CCDD, 32'hAABB_1122,
                                32'hFFFF_8001, 32'h0000_8001, 32'h1234_5678, 32'h1234_5678,
                                32'h0000_007F, 32'h44BB_CCDD, 32'hAABB_CC11};
    int          dly   [11] = '{3, 3, 1, 0, 2, 1, 0, 0, 1, 0, 2};
    wb_allow_in = 1'b1;
    for (int i = 0; i < 11; i++) begin
      set_ex(1, 32'h0040_0100 + i, 1, kinds[i], 1, 5'd9, {30'h0400_0000, offs[i]}, rts[i]);
      step();
      set_ex(0, 0, 0, 0, 0, 0, 0, 0);
      data_sram_rdata = 32'hDEAD_BEEF;
      for (int c = 0; c < dly[i]; c++) begin
        total++; if (io_to_wb_bus.valid !== 1'b0 || io_allow_in !== 1'b0 || io_to_id_bypass.data_ready !== 1'b0)
          begin bad++; $display("FAIL load%0d_wait: got valid=%b allow=%b ready=%b want 0/0/0", i, io_to_wb_bus.valid, io_allow_in, io_to_id_bypass.data_ready); end
        step();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata = rds[i];
      #1;
      total++; if (io_to_wb_bus.valid !== 1'b1) begin bad++; $display("FAIL load%0d_valid: got %b want 1", i, io_to_wb_bus.valid); end
      total++; if (io_to_wb_bus.final_result !== exps[i]) begin bad++; $display("FAIL load%0d_result: got %h want %h", i, io_to_wb_bus.final_result, exps[i]); end
      total++; if (io_to_id_bypass.data !== exps[i] || io_to_id_bypass.data_ready !== 1'b1)
        begin bad++; $display("FAIL load%0d_bypass: got %h ready=%b want %h ready=1", i, io_to_id_bypass.data, io_to_id_bypass.data_ready, exps[i]); end
      step();
      data_sram_data_ok = 1'b0;
      total++; if (io_to_wb_bus.valid !== 1'b0 || dut.data_buffered_q !== 1'b0)
        begin bad++; $display("FAIL load%0d_after: got valid=%b buffered=%b want 0/0", i, io_to_wb_bus.valid, dut.data_buffered_q); end
    end
  endtask

  task automatic test_stall_buffer();
    wb_allow_in = 1'b0;
    set_ex(1, 32'h0040_0200, 1, 3'd0, 1, 5'd12, 32'h1000_0000, 32'h0);
    step();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    #1;
    total++; if (io_to_wb_bus.valid !== 1'b1 || io_allow_in !== 1'b0)
      begin bad++; $display("FAIL stall_first: got valid=%b allow=%b want 1/0", io_to_wb_bus.valid, io_allow_in); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0BAD_0BAD;
    for (int c = 0; c < 4; c++) begin
      total++; if (dut.data_buffered_q !== 1'b1) begin bad++; $display("FAIL stall%0d_buffered: got %b want 1", c, dut.data_buffered_q); end
      total++; if (io_to_wb_bus.final_result !== 32'hCAFE_F00D || io_to_wb_bus.valid !== 1'b1)
        begin bad++; $display("FAIL stall%0d_hold: got %h valid=%b want cafef00d valid=1", c, io_to_wb_bus.final_result, io_to_wb_bus.valid); end
      total++; if (io_to_id_bypass.data_ready !== 1'b1 || io_allow_in !== 1'b0)
        begin bad++; $display("FAIL stall%0d_ready: got ready=%b allow=%b want 1/0", c, io_to_id_bypass.data_ready, io_allow_in); end
      data_sram_rdata = data_sram_rdata + 32'h1111;
      step();
    end
    wb_allow_in = 1'b1;
    #1;
    total++; if (io_to_wb_bus.final_result !== 32'hCAFE_F00D || io_allow_in !== 1'b1)
      begin bad++; $display("FAIL stall_release: got %h allow=%b want cafef00d allow=1", io_to_wb_bus.final_result, io_allow_in); end
    step();
    total++; if (io_to_wb_bus.valid !== 1'b0 || dut.data_buffered_q !== 1'b0)
      begin bad++; $display("FAIL stall_drain: got valid=%b buffered=%b want 0/0", io_to_wb_bus.valid, dut.data_buffered_q); end
  endtask

  task automatic test_back_to_back();
    wb_allow_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 32'h0040_0300 + 4 * i, 0, 0, 1, 5'(i + 1), 32'h100 * (i + 1), 32'h0);
      step();
      total++; if (io_to_wb_bus.valid !== 1'b1 || io_to_wb_bus.final_result !== 32'h100 * (i + 1) || io_allow_in !== 1'b1)
        begin bad++; $display("FAIL stream%0d: got valid=%b result=%h allow=%b want 1/%h/1", i, io_to_wb_bus.valid, io_to_wb_bus.final_result, io_allow_in, 32'h100 * (i + 1)); end
    end
    set_ex(1, 32'h0040_0400, 1, 3'd0, 1, 5'd20, 32'h1000_0000, 32'h0);
    step();
    set_ex(1, 32'h0040_0404, 0, 0, 1, 5'd21, 32'h0000_0ABC, 32'h0);
    for (int c = 0; c < 2; c++) begin
      total++; if (io_allow_in !== 1'b0 || io_to_wb_bus.valid !== 1'b0 || io_to_wb_bus.register_file_address !== 5'd20)
        begin bad++; $display("FAIL pending%0d: got allow=%b valid=%b addr=%0d want 0/0/20", c, io_allow_in, io_to_wb_bus.valid, io_to_wb_bus.register_file_address); end
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h7777_8888;
    #1;
    total++; if (io_allow_in !== 1'b1 || io_to_wb_bus.final_result !== 32'h7777_8888)
      begin bad++; $display("FAIL pending_done: got allow=%b result=%h want 1/77778888", io_allow_in, io_to_wb_bus.final_result); end
    step();
    data_sram_data_ok = 1'b0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (io_to_wb_bus.valid !== 1'b1 || io_to_wb_bus.final_result !== 32'h0000_0ABC || io_to_wb_bus.register_file_address !== 5'd21)
      begin bad++; $display("FAIL follow_on: got valid=%b result=%h addr=%0d want 1/00000abc/21", io_to_wb_bus.valid, io_to_wb_bus.final_result, io_to_wb_bus.register_file_address); end
    step();
  endtask

  task automatic test_async_reset();
    wb_allow_in = 1'b1;
    set_ex(1, 32'h0040_0500, 1, 3'd0, 1, 5'd7, 32'h1000_0000, 32'h0);
    step();
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if (io_to_id_bypass.valid !== 1'b1) begin bad++; $display("FAIL areset_pre: got %b want 1", io_to_id_bypass.valid); end
    #1 reset = 1'b0;
    #1;
    total++; if (dut.io_valid_q !== 1'b0 || io_allow_in !== 1'b1 || io_to_id_bypass.valid !== 1'b0)
      begin bad++; $display("FAIL areset_now: got io_valid=%b allow=%b bypass=%b want 0/1/0", dut.io_valid_q, io_allow_in, io_to_id_bypass.valid); end
    @(negedge clock);
    reset = 1'b1;
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h5A5A_5A5A;
    #1;
    total++; if (io_to_wb_bus.valid !== 1'b0) begin bad++; $display("FAIL areset_late_ok: got %b want 0", io_to_wb_bus.valid); end
    step();
    data_sram_data_ok = 1'b0;
    total++; if (io_to_wb_bus.valid !== 1'b0 || dut.data_buffered_q !== 1'b0)
      begin bad++; $display("FAIL areset_after: got valid=%b buffered=%b want 0/0", io_to_wb_bus.valid, dut.data_buffered_q); end
  endtask

  initial begin
    reset = 1'b0;
    wb_allow_in = 1'b1;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    test_reset();
    test_alu();
    test_load_align();
    test_stall_buffer();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
